// File: rtl/psrv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psrv32_pkg
// Description : Shared PSRV32 definitions: data width, the canonical NOP
//               encoding and the fetch buffer entry (PC + instruction word).
// Revision    : 1.0 - initial release
// ============================================================================
package psrv32_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO with flush and occupancy count.
//               The head entry is read combinationally; it is only meaningful
//               while o_count is non-zero.
// Ports       : i_clk / i_rst_n (async, active-low), i_flush, i_push +
//               i_push_data, i_pop, o_head, o_count
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import psrv32_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  T                       i_push_data,
    input  logic                   i_pop,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

    T                r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_pop;
    logic            w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != c_full) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are never observed while count is zero.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PSRV32 instruction fetch stage. Holds the fetch PC, issues
//               pipelined word reads (req/gnt/rvalid), tags each grant with
//               its PC, buffers returned words and presents them to decode
//               over valid/ready. Taken branches flush the buffer and mark
//               in-flight responses for discard.
// Ports       : clk_i, rst_ni (async, active-low)
//               imem_req_o / imem_addr_o / imem_gnt_i     - request channel
//               imem_rvalid_i / imem_rdata_i              - response channel
//               instr_valid_o / instruction_o / instr_pc_o / instr_ready_i
//               branch_taken_i / branch_target_i          - redirect
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import psrv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i
);

    localparam int            c_cw    = $clog2(DEPTH) + 1;
    localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

    logic [31:0]     r_pc;
    logic [c_cw-1:0] r_discard;
    logic            r_req_hold;

    logic [c_cw-1:0] w_outstanding;
    logic [c_cw-1:0] w_outstanding_nxt;
    logic [c_cw-1:0] w_occupancy;
    logic [c_cw:0]   w_in_flight;
    logic [31:0]     w_target;
    logic [31:0]     w_tag_head;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_buf_empty;
    logic            w_pop;
    logic            w_req_raw;
    logic            w_grant;
    logic            w_resp;
    logic            w_drop;
    logic            w_push;

    assign w_target    = branch_target_i & 32'hFFFF_FFFC;
    assign w_buf_empty = (w_occupancy == '0);
    assign w_pop       = !w_buf_empty && instr_ready_i;

    // Budget credits the word leaving the buffer this cycle so a DEPTH=2
    // buffer sustains one instruction per cycle with single-cycle memory.
    assign w_in_flight = {1'b0, w_outstanding} + {1'b0, w_occupancy}
                       - {{c_cw{1'b0}}, w_pop};

    // Once raised, a request is held until granted; the budget cannot shrink
    // underneath it because only grants add to outstanding + occupancy.
    assign w_req_raw  = rst_ni && (r_req_hold || (w_in_flight < c_depth));
    assign imem_req_o = w_req_raw && !branch_taken_i;
    assign imem_addr_o = r_pc;

    // A grant racing the redirect is still counted so its response is dropped.
    assign w_grant = w_req_raw && imem_gnt_i;
    // Responses with nothing outstanding are protocol errors and are ignored.
    assign w_resp  = imem_rvalid_i && (w_outstanding != '0);
    assign w_drop  = w_resp && (r_discard != '0);
    assign w_push  = w_resp && !w_drop && !branch_taken_i;

    assign w_outstanding_nxt = w_outstanding + c_cw'(w_grant) - c_cw'(w_resp);
    assign w_push_entry      = {w_tag_head, imem_rdata_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc       <= RESET_PC & 32'hFFFF_FFFC;
            r_discard  <= '0;
            r_req_hold <= 1'b0;
        end else if (branch_taken_i) begin
            r_pc       <= w_target;
            r_discard  <= w_outstanding_nxt;
            r_req_hold <= 1'b0;
        end else begin
            if (w_grant) r_pc      <= r_pc + 32'd4;
            if (w_drop)  r_discard <= r_discard - 1'b1;
            r_req_hold <= imem_req_o && !imem_gnt_i;
        end
    end

    // PC-tag queue: one entry per outstanding request; its count is the
    // outstanding counter. Stale tags drain with their (dropped) responses.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_tag_q (
        .i_clk       (clk_i),
        .i_rst_n     (rst_ni),
        .i_flush     (1'b0),
        .i_push      (w_grant),
        .i_push_data (r_pc),
        .i_pop       (w_resp),
        .o_head      (w_tag_head),
        .o_count     (w_outstanding)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_buf (
        .i_clk       (clk_i),
        .i_rst_n     (rst_ni),
        .i_flush     (branch_taken_i),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_occupancy)
    );

    assign instr_valid_o = !w_buf_empty;
    assign instruction_o = w_buf_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc_o    = w_buf_empty ? 32'h0000_0000 : w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A small memory
//               model either auto-grants with one-cycle latency or is driven
//               cycle by cycle from the test tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import psrv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        auto_mem;
    logic        gnt_man;
    logic        rv_man;
    logic [31:0] rd_man;
    logic        r_mem_rv;
    logic [31:0] r_mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory contents: word at address a is a ^ 32'hC0DE_0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_gnt    = auto_mem ? imem_req : gnt_man;
    assign imem_rvalid = auto_mem ? r_mem_rv : rv_man;
    assign imem_rdata  = auto_mem ? mem_word(r_mem_addr) : rd_man;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rv   <= 1'b0;
            r_mem_addr <= 32'h0;
        end else begin
            r_mem_rv   <= imem_req && imem_gnt;
            r_mem_addr <= imem_addr;
        end
    end

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .instr_valid_o   (instr_valid),
        .instruction_o   (instruction),
        .instr_pc_o      (instr_pc),
        .instr_ready_i   (instr_ready),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 2 time units into cycle 0 after reset release.
    task automatic do_reset(input logic auto);
        rst_n = 1'b0; auto_mem = auto; gnt_man = 1'b0; rv_man = 1'b0;
        rd_man = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
        instr_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; auto_mem = 1'b1; instr_ready = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0;
        gnt_man = 1'b0; rv_man = 1'b0; rd_man = 32'h0;
        tick(); tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        n_tests++; if (instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got %h exp 00000013", instruction); end
        n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 00000000", instr_pc); end
    endtask

    // Stream from reset: req in cycle 0, valid from cycle 2, PCs 0,4,8,...
    task automatic test_stream();
        do_reset(1'b1);
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_first_req got %b exp 1", imem_req); end
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_tests++;
            if (instr_valid !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c=%0d got %b exp %b", c, instr_valid, (c >= 2)); end
            if (c >= 2) begin
                n_tests++;
                if (instr_pc !== 32'(4 * (c - 2))) begin n_fail++; $display("FAIL stream_pc c=%0d got %h exp %h", c, instr_pc, 32'(4 * (c - 2))); end
                n_tests++;
                if (instruction !== mem_word(32'(4 * (c - 2)))) begin n_fail++; $display("FAIL stream_instr c=%0d got %h exp %h", c, instruction, mem_word(32'(4 * (c - 2)))); end
            end
        end
    endtask

    // Continues test_stream: cycle 7 showed PC 20, so cycle 8 shows PC 24.
    task automatic test_stall();
        tick();
        instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid i=%0d got %b exp 1", i, instr_valid); end
            n_tests++; if (instr_pc !== 32'd24) begin n_fail++; $display("FAIL stall_pc i=%0d got %h exp 00000018", i, instr_pc); end
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req i=%0d got %b exp 0", i, imem_req); end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid k=%0d got %b exp 1", k, instr_valid); end
            n_tests++; if (instr_pc !== 32'(24 + 4 * k)) begin n_fail++; $display("FAIL resume_pc k=%0d got %h exp %h", k, instr_pc, 32'(24 + 4 * k)); end
            n_tests++; if (instruction !== mem_word(32'(24 + 4 * k))) begin n_fail++; $display("FAIL resume_instr k=%0d got %h exp %h", k, instruction, mem_word(32'(24 + 4 * k))); end
            tick();
        end
    endtask

    // Two requests in flight when the branch to 0x100 arrives.
    task automatic test_redirect_outstanding();
        do_reset(1'b0);
        gnt_man = 1'b1;                       // cycle 0: grant PC 0
        tick();                               // cycle 1: grant PC 4
        tick();                               // cycle 2: two outstanding
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_budget_req got %b exp 0", imem_req); end
        gnt_man = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0100;
        tick();                               // cycle 3
        branch_taken = 1'b0;
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %h exp 00000100", imem_addr); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_stale got %b exp 0", imem_req); end
        rv_man = 1'b1; rd_man = 32'hDEAD_0000;
        tick();                               // cycle 4
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop1_valid got %b exp 0", instr_valid); end
        rd_man = 32'hDEAD_0004;
        tick();                               // cycle 5
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop2_valid got %b exp 0", instr_valid); end
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req_target got %b exp 1", imem_req); end
        rv_man = 1'b0; gnt_man = 1'b1;
        tick();                               // cycle 6
        gnt_man = 1'b0; rv_man = 1'b1; rd_man = mem_word(32'h100);
        tick();                               // cycle 7
        rv_man = 1'b0;
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid got %b exp 1", instr_valid); end
        n_tests++; if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL redir_pc got %h exp 00000100", instr_pc); end
        n_tests++; if (instruction !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_instr got %h exp %h", instruction, mem_word(32'h100)); end
        n_tests++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL redir_next_addr got %h exp 00000104", imem_addr); end
    endtask

    // Branch coincides with a response and a (stale) grant.
    task automatic test_redirect_same_cycle();
        do_reset(1'b0);
        gnt_man = 1'b1;                       // cycle 0: grant PC 0
        tick();                               // cycle 1
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        rv_man = 1'b1; rd_man = 32'hDEAD_0000;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL same_req_forced got %b exp 0", imem_req); end
        tick();                               // cycle 2
        branch_taken = 1'b0; rv_man = 1'b0; gnt_man = 1'b0;
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL same_flush_valid got %b exp 0", instr_valid); end
        n_tests++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL same_addr got %h exp 00000200", imem_addr); end
        gnt_man = 1'b1;
        tick();                               // cycle 3: stale response for PC 4
        gnt_man = 1'b0; rv_man = 1'b1; rd_man = 32'hDEAD_0004;
        tick();                               // cycle 4
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL same_discard_valid got %b exp 0", instr_valid); end
        rd_man = mem_word(32'h200);
        tick();                               // cycle 5
        rv_man = 1'b0;
        n_tests++; if (instr_pc !== 32'h200) begin n_fail++; $display("FAIL same_pc got %h exp 00000200", instr_pc); end
        n_tests++; if (instruction !== mem_word(32'h200)) begin n_fail++; $display("FAIL same_instr got %h exp %h", instruction, mem_word(32'h200)); end
    endtask

    task automatic test_align_wrap();
        do_reset(1'b0);
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        tick();
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL align_addr got %h exp 00000100", imem_addr); end
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre_addr got %h exp fffffffc", imem_addr); end
        gnt_man = 1'b1;
        tick();
        gnt_man = 1'b0;
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        for (int c = 0; c < 4; c++) tick();   // cycle 4 shows PC 8
        #2;
        rst_n = 1'b0;                         // mid-cycle, no clock edge
        #1;
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", instr_valid); end
        n_tests++; if (instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL arst_instr got %h exp 00000013", instruction); end
        n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL arst_pc got %h exp 00000000", instr_pc); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_addr got %h exp 00000000", imem_addr); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_req got %b exp 0", imem_req); end
        do_reset(1'b1);
        tick(); tick();
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL arst_restart got valid=%b pc=%h exp valid=1 pc=00000000", instr_valid, instr_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_align_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
